// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full_adder cell is reused WIDTH times, LSB first,
// with the ripple carry held in a register between steps.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] res_sh_q;
    logic [WIDTH-1:0] res_sh_d;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             c_msb_in_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (c_q),
        .s_o (fa_s),
        .co_o(fa_co)
    );

    // Result bits already produced sit below the new sum bit; the final step completes it.
    assign res_sh_d = {fa_s, res_sh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            cnt_q      <= '0;
            c_q        <= 1'b0;
            c_msb_in_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= sub ? ~b : b;
                        c_q     <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= res_sh_d[WIDTH-1:1];
                    c_q      <= fa_co;
                    // Carry produced by bit WIDTH-2 is the carry into the MSB.
                    if (cnt_q == CW'(WIDTH - 2)) begin
                        c_msb_in_q <= fa_co;
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= res_sh_d;
                        cout_q  <= fa_co;
                        ovf_q   <= c_msb_in_q ^ fa_co;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
